// File: rtl/fetch_queue.sv
// fetch_queue: circular {pc, instr} FIFO between fetch and decode with valid/ready and flush.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when the queue is empty.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [63:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic empty;
    logic bypass;
    logic push, pop;
    logic byp_take;
    logic wr_en, rd_en;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL);
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = ~flush & (~empty | bypass);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    // A bypassed beat consumed in the same cycle never touches storage.
    assign byp_take  = bypass & out_ready;
    assign wr_en     = push & ~byp_take;
    assign rd_en     = pop & ~byp_take;

    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (~flush & ~empty) begin
            out_pc    = pc_mem[rd_ptr_q];
            out_instr = instr_mem[rd_ptr_q];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en & ~flush) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus for fetch_queue against a queue-based model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [63:0]    in_pc = '0;
    logic [31:0]    in_instr = '0;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [63:0]    out_pc;
    logic [31:0]    out_instr;
    logic [PTR_W:0] count;

    int    errors = 0;
    int    checks = 0;
    beat_t mq[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle, check outputs mid-cycle against the model, then advance the model.
    task automatic step(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input string tag);
        logic        e_rdy, e_vld, byp;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        beat_t       b;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #3;
        e_rdy = (mq.size() != DEPTH);
        byp   = BYP && mq.size() == 0 && iv && !fl;
        e_vld = !fl && (mq.size() != 0 || byp);
        e_pc  = '0;
        e_ins = '0;
        if (e_vld) begin
            if (mq.size() != 0) begin
                e_pc  = mq[0].pc;
                e_ins = mq[0].instr;
            end else begin
                e_pc  = pc;
                e_ins = ins;
            end
        end
        check({tag, ".count"},     64'(count),     64'(mq.size()));
        check({tag, ".in_ready"},  64'(in_ready),  64'(e_rdy));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(e_vld));
        check({tag, ".out_pc"},    out_pc,         e_pc);
        check({tag, ".out_instr"}, 64'(out_instr), 64'(e_ins));
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else if (!(byp && ordy)) begin
            if (e_vld && ordy) void'(mq.pop_front());
            if (iv && e_rdy) begin
                b.pc    = pc;
                b.instr = ins;
                mq.push_back(b);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic ordy, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, ordy, 1'b0, tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst0.count", 64'(count), 64'd0);
        check("rst0.out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;

        // Sequential fetch with decode always ready
        step(1'b1, 64'h0, 32'h11111111, 1'b1, 1'b0, "seq0");
        step(1'b1, 64'h4, 32'hAAAAAAAA, 1'b1, 1'b0, "seq1");
        step(1'b1, 64'h8, 32'h22222222, 1'b1, 1'b0, "seq2");
        idle(2, 1'b1, "seqd");

        // Fill with decode stalled; fifth beat is held
        for (int i = 0; i < 5; i++)
            step(1'b1, 64'(i * 4), 32'hC0DE0000 + 32'(i), 1'b0, 1'b0, "fill");
        step(1'b1, 64'h10, 32'hC0DE0004, 1'b0, 1'b0, "hold");
        step(1'b1, 64'h10, 32'hC0DE0004, 1'b1, 1'b0, "pop1");
        step(1'b1, 64'h10, 32'hC0DE0004, 1'b0, 1'b0, "acc5");
        idle(6, 1'b1, "drain");

        // Simultaneous push+pop at count=2
        step(1'b1, 64'h40, 32'h40, 1'b0, 1'b0, "pp_a");
        step(1'b1, 64'h44, 32'h44, 1'b0, 1'b0, "pp_b");
        step(1'b1, 64'h48, 32'h48, 1'b1, 1'b0, "pp_c");
        idle(1, 1'b0, "pp_chk");
        idle(3, 1'b1, "pp_drain");

        // Flush with count=3 and an incoming beat
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h80 + 64'(i * 4), 32'h80 + 32'(i), 1'b0, 1'b0, "fl_fill");
        step(1'b1, 64'h100, 32'h100, 1'b1, 1'b1, "flush");
        idle(1, 1'b0, "fl_post");
        step(1'b1, 64'h104, 32'h104, 1'b0, 1'b0, "fl_push");
        idle(1, 1'b0, "fl_head");
        idle(2, 1'b1, "fl_drain");

        // Empty-queue latency (bypass when enabled)
        step(1'b1, 64'h200, 32'h200, 1'b1, 1'b0, "byp");
        idle(1, 1'b1, "byp_next");
        step(1'b1, 64'h204, 32'h204, 1'b0, 1'b0, "byp_stall");
        idle(2, 1'b1, "byp_drain");

        // Asynchronous reset mid-run with count=3
        for (int i = 0; i < 3; i++)
            step(1'b1, 64'h300 + 64'(i * 4), 32'h300 + 32'(i), 1'b0, 1'b0, "r_fill");
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("rst_pre.count", 64'(count), 64'd3);
        rst = 1'b0;
        #2;
        check("rst.count",     64'(count),     64'd0);
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.out_pc",    out_pc,         64'd0);
        check("rst.out_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        idle(1, 1'b1, "rst_rel");

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, "rnd");
        idle(6, 1'b1, "rnd_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
